// File: rtl/weight_fetch_ctrl_if.sv
// Weight fetch bus: BRAM read port plus the weight stream towards the MAC.
interface weight_fetch_ctrl_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 5
);
  logic [ADDR_W-1:0] bram_addr;
  logic              bram_en;
  logic              bram_we;
  logic [DATA_W-1:0] bram_di;
  logic [DATA_W-1:0] bram_do;
  logic [DATA_W-1:0] w_data;
  logic              w_valid;
  logic              w_last;
  logic              w_ready;

  // Fetch controller side: drives the BRAM port and sources the weight stream.
  modport master (
    output bram_addr, bram_en, bram_we, bram_di,
    input  bram_do,
    output w_data, w_valid, w_last,
    input  w_ready
  );

  // BRAM/MAC side.
  modport slave (
    input  bram_addr, bram_en, bram_we, bram_di,
    output bram_do,
    input  w_data, w_valid, w_last,
    output w_ready
  );
endinterface

// File: rtl/weight_fetch_ctrl.sv
// Weight fetch controller: reads COUNT consecutive words from one BRAM
// (wrapping at DEPTH) and streams them to the MAC through a 2-entry buffer.
module weight_fetch_ctrl #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DEPTH  = 28,
  parameter int unsigned BUF_D  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W:0]     count,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  weight_fetch_ctrl_if.master bus
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned OCC_W = 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_FINISH
  } state_t;

  typedef struct packed {
    logic              vld;
    logic              last;
    logic [DATA_W-1:0] data;
  } entry_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
  logic [CNT_W-1:0]  remaining_q, remaining_d;
  logic [ADDR_W-1:0] bram_addr_q, bram_addr_d;
  logic              bram_en_q, bram_en_d;
  logic              infl_last_q, infl_last_d;
  entry_t            head_q, head_d;
  entry_t            tail_q, tail_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              pop;
  logic              issue;
  logic [OCC_W-1:0]  occ_after;
  entry_t            captured;

  // Occupancy left after this edge: buffered words plus the read in flight, minus the word leaving.
  always_comb begin
    pop       = head_q.vld & bus.w_ready;
    occ_after = OCC_W'(head_q.vld) + OCC_W'(tail_q.vld) + OCC_W'(bram_en_q) - OCC_W'(pop);
    issue     = (state_q == S_FETCH) && (remaining_q != '0) && (occ_after < OCC_W'(BUF_D));
    captured  = {1'b1, infl_last_q, bus.bram_do};
  end

  // Next-state, read issue and buffer update.
  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    remaining_d  = remaining_q;
    bram_addr_d  = bram_addr_q;
    bram_en_d    = 1'b0;
    infl_last_d  = 1'b0;
    head_d       = head_q;
    tail_d       = tail_q;
    busy_d       = 1'b0;
    done_d       = 1'b0;

    if (pop) begin
      head_d = tail_q;
      tail_d = '0;
    end
    if (bram_en_q) begin
      if (!head_d.vld) begin
        head_d = captured;
      end else begin
        tail_d = captured;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          fetch_addr_d = base_addr;
          remaining_d  = count;
          state_d      = (count == '0) ? S_FINISH : S_FETCH;
        end
      end
      S_FETCH: begin
        if (issue) begin
          bram_en_d    = 1'b1;
          bram_addr_d  = fetch_addr_q;
          infl_last_d  = (remaining_q == CNT_W'(1));
          fetch_addr_d = (fetch_addr_q == ADDR_W'(DEPTH - 1)) ? '0 : fetch_addr_q + ADDR_W'(1);
          remaining_d  = remaining_q - CNT_W'(1);
          if (remaining_q == CNT_W'(1)) begin
            state_d = S_DRAIN;
          end
        end else if (remaining_q == '0) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (occ_after == '0) begin
          state_d = S_FINISH;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Cancel drops the buffer and any word still coming back from the BRAM.
    if (abort && (state_q != S_IDLE)) begin
      state_d     = S_IDLE;
      bram_en_d   = 1'b0;
      infl_last_d = 1'b0;
      remaining_d = '0;
      head_d      = '0;
      tail_d      = '0;
    end

    busy_d = (state_d == S_FETCH) || (state_d == S_DRAIN);
    done_d = (state_d == S_FINISH);
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      fetch_addr_q <= '0;
      remaining_q  <= '0;
      bram_addr_q  <= '0;
      bram_en_q    <= 1'b0;
      infl_last_q  <= 1'b0;
      head_q       <= '0;
      tail_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      remaining_q  <= remaining_d;
      bram_addr_q  <= bram_addr_d;
      bram_en_q    <= bram_en_d;
      infl_last_q  <= infl_last_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign bus.bram_addr = bram_addr_q;
  assign bus.bram_en   = bram_en_q;
  assign bus.bram_we   = 1'b0;
  assign bus.bram_di   = '0;
  assign bus.w_data    = head_q.data;
  assign bus.w_valid   = head_q.vld;
  assign bus.w_last    = head_q.last;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// Bench for weight_fetch_ctrl: job table, hand-written abort/reset sequences
// and random jobs checked against an address/data model of the BRAM.
module tb_weight_fetch_ctrl;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DEPTH  = 28;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [ADDR_W:0]   count = '0;
  logic              busy;
  logic              done;

  int total = 0;
  int bad = 0;

  logic [DATA_W-1:0] mem [32];

  weight_fetch_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) wif ();

  weight_fetch_ctrl #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .BUF_D(2)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .count(count),
    .abort(abort), .busy(busy), .done(done), .bus(wif)
  );

  always #5 clk = ~clk;

  // Negedge-read BRAM.
  always @(negedge clk) begin
    if (wif.bram_en) wif.bram_do <= mem[wif.bram_addr];
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit ready_for(input int mode, input int cyc);
    case (mode)
      0:       return 1'b1;
      1:       return (cyc % 3) == 0;
      2:       return 1'($urandom_range(0, 1));
      default: return $urandom_range(0, 3) == 0;
    endcase
  endfunction

  task automatic load_default();
    for (int i = 0; i < 32; i++) mem[i] = (i < int'(DEPTH)) ? DATA_W'(i + 100) : '0;
  endtask

  // Runs one job from IDLE and checks it against the expected address/data sequence.
  task automatic run_job(input string tag, input int base, input int cnt, input int mode,
                         input int poke, output int n_got, output int first_got,
                         output int last_got);
    int got_d[$];
    bit got_l[$];
    int addrs[$];
    int done_cyc = -1;
    int ndone = 0;
    int first_valid = -1;
    int first_x = -1;
    int last_x = -1;
    int outstanding = 0;
    int max_out = 0;
    int unstable = 0;
    int addr_err = 0;
    int last_err = 0;
    bit busy_at1 = 1'b0;
    bit busy_at_done = 1'b1;
    bit prev_stall = 1'b0;
    bit prev_last = 1'b0;
    logic [DATA_W-1:0] prev_data = '0;
    int idx;
    for (int cyc = 0; cyc < 400; cyc++) begin
      step();
      abort = 1'b0;
      if (cyc == 0) begin
        start = 1'b1; base_addr = 5'(base); count = 6'(cnt);
      end else if (cyc == poke) begin
        start = 1'b1; base_addr = 5'((base + 7) % int'(DEPTH)); count = 6'd3;
      end else begin
        start = 1'b0;
      end
      if (wif.bram_en) begin
        addrs.push_back(int'(wif.bram_addr));
        outstanding++;
      end
      if (outstanding > max_out) max_out = outstanding;
      if (prev_stall && (!wif.w_valid || wif.w_data != prev_data || wif.w_last != prev_last))
        unstable++;
      if (wif.w_valid && first_valid < 0) first_valid = cyc;
      if (cyc == 1) busy_at1 = busy;
      if (done) begin
        ndone++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
          busy_at_done = busy;
        end
      end
      wif.w_ready = ready_for(mode, cyc);
      if (wif.w_valid && wif.w_ready) begin
        got_d.push_back(int'(wif.w_data));
        got_l.push_back(wif.w_last);
        outstanding--;
        if (first_x < 0) first_x = cyc;
        last_x = cyc;
      end
      prev_stall = wif.w_valid && !wif.w_ready;
      prev_data  = wif.w_data;
      prev_last  = wif.w_last;
      if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
    end
    start = 1'b0;

    check({tag, " done seen"}, done_cyc >= 0, 1);
    check({tag, " words"}, got_d.size(), cnt);
    check({tag, " reads"}, addrs.size(), cnt);
    for (int i = 0; i < got_d.size() && i < cnt; i++) begin
      idx = (base + i) % int'(DEPTH);
      check($sformatf("%s data[%0d]", tag, i), got_d[i], int'(mem[idx]));
      if (got_l[i] != (i == cnt - 1)) last_err++;
    end
    for (int i = 0; i < addrs.size() && i < cnt; i++) begin
      if (addrs[i] != (base + i) % int'(DEPTH)) addr_err++;
    end
    check({tag, " addr errors"}, addr_err, 0);
    check({tag, " last errors"}, last_err, 0);
    check({tag, " done pulses"}, ndone, 1);
    check({tag, " done cycle"}, done_cyc, (cnt == 0) ? 1 : last_x + 1);
    check({tag, " busy at done"}, busy_at_done, 0);
    check({tag, " busy after start"}, busy_at1, cnt > 0);
    check({tag, " outstanding<=2"}, max_out <= 2, 1);
    check({tag, " stall stability"}, unstable, 0);
    check({tag, " first valid cycle"}, first_valid, (cnt > 0) ? 3 : -1);
    if (mode == 0 && cnt > 0) check({tag, " throughput"}, last_x - first_x, cnt - 1);
    n_got     = got_d.size();
    first_got = (got_d.size() > 0) ? got_d[0] : 0;
    last_got  = (got_d.size() > 0) ? got_d[got_d.size() - 1] : 0;
  endtask

  typedef struct {
    string name;
    int    base;
    int    cnt;
    int    mode;
    int    poke;
    int    exp_n;
    int    exp_first;
    int    exp_last;
  } vec_t;

  initial begin
    vec_t vecs[7];
    int n, f, l, flag;
    vecs[0] = '{"full28",     0, 28, 0, -1, 28, 100, 127};
    vecs[1] = '{"wrap",      25,  5, 0, -1,  5, 125, 101};
    vecs[2] = '{"stall100",   3,  8, 1, -1,  8, 103, 110};
    vecs[3] = '{"count0",     6,  0, 0, -1,  0,   0,   0};
    vecs[4] = '{"single_top",27,  1, 1, -1,  1, 127, 127};
    vecs[5] = '{"rand_rdy",  13, 28, 2, -1, 28, 113, 112};
    vecs[6] = '{"start_busy",20, 12, 3,  4, 12, 120, 103};

    load_default();
    wif.w_ready = 1'b0;
    rst = 1'b1;
    step();
    step();
    check("rst w_valid", wif.w_valid, 0);
    check("rst w_last", wif.w_last, 0);
    check("rst w_data", wif.w_data, 0);
    check("rst bram_en", wif.bram_en, 0);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 7; i++) begin
      run_job(vecs[i].name, vecs[i].base, vecs[i].cnt, vecs[i].mode, vecs[i].poke, n, f, l);
      check({vecs[i].name, " tbl words"}, n, vecs[i].exp_n);
      if (vecs[i].exp_n > 0) begin
        check({vecs[i].name, " tbl first"}, f, vecs[i].exp_first);
        check({vecs[i].name, " tbl last"}, l, vecs[i].exp_last);
      end
    end
    check("bram_we held", wif.bram_we, 0);
    check("bram_di held", wif.bram_di, 0);

    // Abort after the third transfer of a 10-word job.
    step();
    start = 1'b1; base_addr = 5'd0; count = 6'd10; wif.w_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 40 && n < 3; c++) begin
      step();
      start = 1'b0;
      if (wif.w_valid) n++;
    end
    check("abort pre xfers", n, 3);
    step();
    abort = 1'b1; wif.w_ready = 1'b0;
    step();
    abort = 1'b0;
    check("abort w_valid", wif.w_valid, 0);
    check("abort busy", busy, 0);
    check("abort bram_en", wif.bram_en, 0);
    flag = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (done || wif.w_valid || wif.bram_en || busy) flag++;
    end
    check("abort quiet", flag, 0);
    run_job("after_abort", 4, 2, 0, -1, n, f, l);
    check("after_abort first", f, 104);
    check("after_abort last", l, 105);

    // START together with ABORT in IDLE is dropped.
    step();
    start = 1'b1; abort = 1'b1; base_addr = 5'd0; count = 6'd5;
    step();
    start = 1'b0; abort = 1'b0;
    flag = 0;
    for (int c = 0; c < 4; c++) begin
      if (busy || wif.bram_en || done || wif.w_valid) flag++;
      step();
    end
    check("start+abort idle", flag, 0);

    // Asynchronous reset in the middle of a stalled job.
    start = 1'b1; base_addr = 5'd7; count = 6'd10; wif.w_ready = 1'b0;
    step();
    start = 1'b0;
    step(); step(); step();
    check("pre-rst w_valid", wif.w_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    check("mid rst w_valid", wif.w_valid, 0);
    check("mid rst w_data", wif.w_data, 0);
    check("mid rst bram_en", wif.bram_en, 0);
    check("mid rst bram_addr", wif.bram_addr, 0);
    check("mid rst busy", busy, 0);
    step();
    rst = 1'b0;
    run_job("post_rst", 9, 1, 0, -1, n, f, l);
    check("post_rst word", f, 109);

    // Random contents, jobs and backpressure.
    for (int j = 0; j < 8; j++) begin
      int b, c, m, p;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] = DATA_W'($urandom_range(0, 65535));
      b = $urandom_range(0, DEPTH - 1);
      c = $urandom_range(0, DEPTH);
      m = $urandom_range(0, 3);
      p = (c > 0 && $urandom_range(0, 1) == 1) ? 3 : -1;
      run_job($sformatf("rnd%0d", j), b, c, m, p, n, f, l);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
